// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared funct3 codes, byte-lane masks and state type for the
//               BRAM load/store ports.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] LANE_MASK_B = 4'b0001;
    localparam logic [3:0] LANE_MASK_H = 4'b0011;
    localparam logic [3:0] LANE_MASK_W = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_t;

    // Stores have no unsigned variants, so BU/HU are illegal with we=1.
    function automatic logic f3_is_illegal(input logic [2:0] f3, input logic we);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
               (we && ((f3 == F3_BU) || (f3 == F3_HU)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_load_align
// Description : Extracts the addressed byte/half from a BRAM word and
//               sign- or zero-extends it according to funct3.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] dout,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = dout[{offset, 3'b000} +: 8];
        w_half = dout[{offset[1], 4'b0000} +: 16];
        case (funct3)
            F3_B:    rdata = {{24{w_byte[7]}}, w_byte};
            F3_BU:   rdata = {24'd0, w_byte};
            F3_H:    rdata = {{16{w_half[15]}}, w_half};
            F3_HU:   rdata = {16'd0, w_half};
            default: rdata = dout;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bram_lsu_port.sv
`default_nettype none
// ============================================================================
// Module      : bram_lsu_port
// Description : Single-outstanding load/store initiator for one 32-bit port
//               of the data BRAM, with alignment/range checking.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_lsu_port
    import lsu_pkg::*;
#(
    parameter int          READ_LATENCY = 1,
    parameter int          DEPTH_WORDS  = 4096,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        bram_en,
    output logic [3:0]  bram_we,
    output logic [31:0] bram_addr,
    output logic [31:0] bram_din,
    input  logic [31:0] bram_dout
);

    localparam logic [32:0] c_limit     = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);
    localparam logic [1:0]  c_wait_init = 2'(READ_LATENCY - 1);

    lsu_state_t  r_state;
    lsu_state_t  w_state_nxt;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic        r_we;
    logic [1:0]  r_wait_cnt;

    logic        w_accept;
    logic        w_misalign;
    logic        w_out_of_range;
    logic        w_err;
    logic [3:0]  w_lane_mask;
    logic [31:0] w_store_data;
    logic [31:0] w_word_addr;
    logic [31:0] w_load_data;

    assign req_ready   = (r_state == ST_IDLE) && !rst;
    assign w_accept    = req_valid && req_ready;
    assign w_word_addr = (req_addr - BASE_ADDR) >> 2;

    always_comb begin
        w_misalign   = 1'b0;
        w_lane_mask  = LANE_MASK_W;
        w_store_data = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                w_lane_mask  = LANE_MASK_B << req_addr[1:0];
                w_store_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_misalign   = req_addr[0];
                w_lane_mask  = LANE_MASK_H << req_addr[1:0];
                w_store_data = {2{req_wdata[15:0]}};
            end
            default: w_misalign = (req_addr[1:0] != 2'b00);
        endcase
        w_out_of_range = ({1'b0, req_addr} < {1'b0, BASE_ADDR}) ||
                         ({1'b0, req_addr} >= c_limit);
        w_err = w_misalign || w_out_of_range || f3_is_illegal(req_funct3, req_we);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_state_nxt = w_err ? ST_RESP : ST_ACCESS;
            ST_ACCESS: w_state_nxt = r_we ? ST_RESP : ST_WAIT;
            ST_WAIT:   if (r_wait_cnt == 2'd0) w_state_nxt = ST_RESP;
            ST_RESP:   if (resp_ready) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    lsu_load_align u_align (
        .dout   (bram_dout),
        .funct3 (r_funct3),
        .offset (r_off),
        .rdata  (w_load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_funct3   <= '0;
            r_off      <= '0;
            r_we       <= 1'b0;
            r_wait_cnt <= '0;
            bram_en    <= 1'b0;
            bram_we    <= '0;
            bram_addr  <= '0;
            bram_din   <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            bram_en <= 1'b0;
            bram_we <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_funct3 <= req_funct3;
                        r_off    <= req_addr[1:0];
                        r_we     <= req_we;
                        if (w_err) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            bram_en   <= 1'b1;
                            bram_addr <= w_word_addr;
                            // Loads leave din untouched so the port only toggles on stores.
                            if (req_we) begin
                                bram_we  <= w_lane_mask;
                                bram_din <= w_store_data;
                            end
                        end
                    end
                end
                ST_ACCESS: begin
                    if (r_we) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                    end else begin
                        r_wait_cnt <= c_wait_init;
                    end
                end
                ST_WAIT: begin
                    if (r_wait_cnt == 2'd0) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= w_load_data;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 2'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bram_lsu_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_lsu_port
// Description : Directed bench for bram_lsu_port at READ_LATENCY 1 and 2,
//               with a transaction-level reference model checked every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bram_lsu_port;

    localparam int          DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_ready = 1'b1;

    logic        d_ready  [2];
    logic        d_rvalid [2];
    logic        d_err    [2];
    logic        d_en     [2];
    logic [3:0]  d_we     [2];
    logic [31:0] d_rdata  [2];
    logic [31:0] d_addr   [2];
    logic [31:0] d_din    [2];
    logic [31:0] d_dout   [2];

    logic [31:0] bram    [2][DEPTH];
    logic [31:0] pipe    [2][3];
    logic [31:0] ref_mem [DEPTH];

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bram_lsu_port #(.READ_LATENCY(1)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(d_ready[0]),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(d_rvalid[0]), .resp_ready(resp_ready), .resp_rdata(d_rdata[0]), .resp_err(d_err[0]),
        .bram_en(d_en[0]), .bram_we(d_we[0]), .bram_addr(d_addr[0]), .bram_din(d_din[0]),
        .bram_dout(d_dout[0])
    );

    bram_lsu_port #(.READ_LATENCY(2)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(d_ready[1]),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(d_rvalid[1]), .resp_ready(resp_ready), .resp_rdata(d_rdata[1]), .resp_err(d_err[1]),
        .bram_en(d_en[1]), .bram_we(d_we[1]), .bram_addr(d_addr[1]), .bram_din(d_din[1]),
        .bram_dout(d_dout[1])
    );

    // BRAM behaviour: byte-enabled write, read data delayed by each instance's latency.
    logic [31:0] nw;
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (d_en[i]) begin
                nw = bram[i][d_addr[i][11:0]];
                for (int b = 0; b < 4; b++)
                    if (d_we[i][b]) nw[8*b +: 8] = d_din[i][8*b +: 8];
                bram[i][d_addr[i][11:0]] <= nw;
                pipe[i][0] <= bram[i][d_addr[i][11:0]];
            end else begin
                pipe[i][0] <= 32'hBAD0_BAD0;
            end
            pipe[i][1] <= pipe[i][0];
            pipe[i][2] <= pipe[i][1];
        end
    end
    assign d_dout[0] = pipe[0][0];
    assign d_dout[1] = pipe[1][1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference behaviour of one request, computed from the access rules directly.
    task automatic model_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, output logic err, output logic [3:0] wm,
                             output logic [31:0] wa, output logic [31:0] din, output logic [31:0] rd);
        int unsigned size;
        longint      la;
        logic [31:0] sh;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        la   = longint'(a);
        err  = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]) ||
               (a % size != 0) || (la < longint'(BASE)) || (la >= longint'(BASE) + 4 * DEPTH);
        wa   = (a - BASE) / 4;
        wm   = we ? 4'(((1 << size) - 1) << (a % 4)) : 4'b0000;
        din  = (size == 1) ? {24'd0, wd[7:0]} * 32'h0101_0101 :
               (size == 2) ? {16'd0, wd[15:0]} * 32'h0001_0001 : wd;
        rd   = '0;
        if (!err && !we) begin
            sh = ref_mem[wa[11:0]] >> (8 * (a % 4));
            if (size == 1) begin
                rd = sh & 32'hFF;
                if (!f3[2] && rd[7]) rd = rd | 32'hFFFF_FF00;
            end else if (size == 2) begin
                rd = sh & 32'hFFFF;
                if (!f3[2] && rd[15]) rd = rd | 32'hFFFF_0000;
            end else begin
                rd = sh;
            end
        end
    endtask

    logic        busy [2] = '{1'b0, 1'b0};
    int          acc  [2];
    logic        m_err [2], m_st [2];
    logic [3:0]  m_we [2];
    logic [31:0] m_addr [2], m_din [2], m_rdata [2];
    int          rc;
    logic        vexp, enexp;
    logic        t_err;
    logic [3:0]  t_wm;
    logic [31:0] t_wa, t_din, t_rd;

    always @(negedge clk) begin
        if (cyc >= 1) begin
            for (int i = 0; i < 2; i++) begin
                rc    = acc[i] + (m_err[i] ? 1 : (m_st[i] ? 2 : 2 + (i + 1)));
                vexp  = busy[i] && (cyc >= rc);
                enexp = busy[i] && !m_err[i] && (cyc == acc[i] + 1);
                chk($sformatf("u%0d req_ready", i), 32'(d_ready[i]), 32'(!busy[i] && !rst));
                chk($sformatf("u%0d bram_en", i), 32'(d_en[i]), 32'(enexp));
                if (enexp) begin
                    chk($sformatf("u%0d bram_we", i), 32'(d_we[i]), 32'(m_st[i] ? m_we[i] : 4'b0000));
                    chk($sformatf("u%0d bram_addr", i), d_addr[i], m_addr[i]);
                    if (m_st[i]) chk($sformatf("u%0d bram_din", i), d_din[i], m_din[i]);
                end else begin
                    chk($sformatf("u%0d bram_we idle", i), 32'(d_we[i]), 32'd0);
                end
                chk($sformatf("u%0d resp_valid", i), 32'(d_rvalid[i]), 32'(vexp));
                if (vexp) begin
                    chk($sformatf("u%0d resp_rdata", i), d_rdata[i], m_rdata[i]);
                    chk($sformatf("u%0d resp_err", i), 32'(d_err[i]), 32'(m_err[i]));
                end
                if (rst) begin
                    busy[i] = 1'b0;
                end else if (vexp && resp_ready) begin
                    busy[i] = 1'b0;
                end else if (!busy[i] && req_valid) begin
                    busy[i] = 1'b1;
                    acc[i]  = cyc;
                    model_req(req_we, req_funct3, req_addr, req_wdata, t_err, t_wm, t_wa, t_din, t_rd);
                    m_err[i] = t_err; m_we[i] = t_wm; m_addr[i] = t_wa;
                    m_din[i] = t_din; m_rdata[i] = t_rd; m_st[i] = req_we;
                    if (i == 0 && !t_err && req_we)
                        for (int b = 0; b < 4; b++)
                            if (t_wm[b]) ref_mem[t_wa[11:0]][8*b +: 8] = t_din[8*b +: 8];
                end
            end
        end
    end

    int          en_lat;
    logic [3:0]  en_we;
    logic [31:0] en_addr, en_din;

    task automatic wait_idle();
        int k;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!(d_ready[0] && d_ready[1]) && k < 40);
        chk("idle timeout", 32'(d_ready[0] && d_ready[1]), 32'd1);
    endtask

    task automatic issue(input string nm, input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic exp_err, input logic [31:0] exp_rd,
                         input int exp_lat0, input int exp_lat1);
        int n, s0, s1;
        logic [31:0] rd0, rd1;
        logic e0;
        wait_idle();
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(negedge clk); n = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
        s0 = -1; s1 = -1; en_lat = -1; rd0 = 'x; rd1 = 'x; e0 = 1'bx;
        for (int k = 0; k < 12 && (s0 < 0 || s1 < 0); k++) begin
            @(negedge clk);
            if (en_lat < 0 && d_en[0]) begin
                en_lat = cyc - n; en_we = d_we[0]; en_addr = d_addr[0]; en_din = d_din[0];
            end
            if (s0 < 0 && d_rvalid[0]) begin s0 = cyc - n; rd0 = d_rdata[0]; e0 = d_err[0]; end
            if (s1 < 0 && d_rvalid[1]) begin s1 = cyc - n; rd1 = d_rdata[1]; end
        end
        chk({nm, " latency L1"}, 32'(s0), 32'(exp_lat0));
        chk({nm, " latency L2"}, 32'(s1), 32'(exp_lat1));
        chk({nm, " rdata L1"}, rd0, exp_rd);
        chk({nm, " rdata L2"}, rd1, exp_rd);
        chk({nm, " err"}, 32'(e0), 32'(exp_err));
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) begin
            ref_mem[k] = {16'(k), ~16'(k)};
            bram[0][k] = ref_mem[k];
            bram[1][k] = ref_mem[k];
        end
    end

    initial begin
        int n, h;
        // Reset, with a request presented during the final reset cycle.
        repeat (2) begin @(posedge clk); #1; end
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20;
        @(negedge clk);
        chk("reset bram_en", 32'(d_en[0]), 32'd0);
        chk("reset bram_we", 32'(d_we[0]), 32'd0);
        chk("reset bram_addr", d_addr[0], 32'd0);
        chk("reset bram_din", d_din[0], 32'd0);
        chk("reset resp_valid", 32'(d_rvalid[0]), 32'd0);
        chk("reset resp_rdata", d_rdata[0], 32'd0);
        chk("reset resp_err", 32'(d_err[0]), 32'd0);
        chk("reset req_ready", 32'(d_ready[0]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;

        // Word store and byte store lane generation.
        issue("SW 0x10", 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, 2, 2);
        chk("SW en latency", 32'(en_lat), 32'd1);
        chk("SW bram_we", 32'(en_we), 32'hF);
        chk("SW bram_addr", en_addr, 32'h4);
        chk("SW bram_din", en_din, 32'hDEAD_BEEF);
        issue("SB 0x13", 1'b1, 3'b000, 32'h13, 32'h1234_56A5, 1'b0, 32'h0, 2, 2);
        chk("SB bram_we", 32'(en_we), 32'h8);
        chk("SB bram_din", en_din, 32'hA5A5_A5A5);
        issue("LB 0x13", 1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 32'hFFFF_FFA5, 3, 4);
        issue("LBU 0x13", 1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 32'h0000_00A5, 3, 4);

        // Half-word loads, both read latencies.
        issue("SW 0x10 b", 1'b1, 3'b010, 32'h10, 32'h8001_7FFF, 1'b0, 32'h0, 2, 2);
        issue("LH 0x12", 1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 32'hFFFF_8001, 3, 4);
        issue("LHU 0x12", 1'b0, 3'b101, 32'h12, 32'h0, 1'b0, 32'h0000_8001, 3, 4);
        issue("LH 0x10", 1'b0, 3'b001, 32'h10, 32'h0, 1'b0, 32'h0000_7FFF, 3, 4);
        issue("LB 0x11", 1'b0, 3'b000, 32'h11, 32'h0, 1'b0, 32'h0000_007F, 3, 4);
        issue("SH 0x16", 1'b1, 3'b001, 32'h16, 32'h0000_C3D2, 1'b0, 32'h0, 2, 2);
        chk("SH bram_we", 32'(en_we), 32'hC);
        chk("SH bram_din", en_din, 32'hC3D2_C3D2);
        issue("LW 0x14", 1'b0, 3'b010, 32'h14, 32'h0, 1'b0, 32'hC3D2_FFFA, 3, 4);
        issue("LW last", 1'b0, 3'b010, 32'h3FFC, 32'h0, 1'b0, 32'h0FFF_F000, 3, 4);

        // Error responses never enable the BRAM.
        issue("LW 0x06", 1'b0, 3'b010, 32'h06, 32'h0, 1'b1, 32'h0, 1, 1);
        chk("LW 0x06 no en", 32'(en_lat), 32'hFFFF_FFFF);
        issue("SH 0x01", 1'b1, 3'b001, 32'h01, 32'h0, 1'b1, 32'h0, 1, 1);
        chk("SH 0x01 no en", 32'(en_lat), 32'hFFFF_FFFF);
        issue("f3 011", 1'b0, 3'b011, 32'h20, 32'h0, 1'b1, 32'h0, 1, 1);
        issue("LW limit", 1'b0, 3'b010, 32'h4000, 32'h0, 1'b1, 32'h0, 1, 1);
        chk("LW limit no en", 32'(en_lat), 32'hFFFF_FFFF);
        issue("SBU store", 1'b1, 3'b100, 32'h20, 32'h0, 1'b1, 32'h0, 1, 1);

        // Back-pressure: response held, concurrent request waits for the handshake.
        wait_idle();
        resp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
        @(negedge clk); n = cyc;
        @(posedge clk); #1;
        req_funct3 = 3'b100; req_addr = 32'h11;
        repeat (8) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("hold resp_valid", 32'(d_rvalid[0]), 32'd1);
        chk("hold rdata", d_rdata[0], 32'h8001_7FFF);
        chk("hold req_ready", 32'(d_ready[0]), 32'd0);
        chk("hold cycle", 32'(cyc - n), 32'd9);
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk); h = cyc;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        @(negedge clk);
        chk("post-hs req_ready", 32'(d_ready[0]), 32'd1);
        chk("post-hs resp_valid", 32'(d_rvalid[0]), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0; resp_ready = 1'b1;
        @(negedge clk);
        chk("post-hs bram_en", 32'(d_en[0]), 32'd1);
        repeat (2) @(negedge clk);
        chk("post-hs LBU rdata", d_rdata[0], 32'h0000_007F);
        chk("post-hs LBU cycle", 32'(cyc - h), 32'd4);

        // Reset during WAIT aborts the load.
        wait_idle();
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; req_valid = 1'b1; req_addr = 32'h20;
        @(negedge clk);
        chk("rst req_ready", 32'(d_ready[0]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("abort bram_en L1", 32'(d_en[0]), 32'd0);
        chk("abort bram_en L2", 32'(d_en[1]), 32'd0);
        chk("abort resp_valid L1", 32'(d_rvalid[0]), 32'd0);
        chk("abort resp_valid L2", 32'(d_rvalid[1]), 32'd0);
        chk("abort req_ready", 32'(d_ready[0] && d_ready[1]), 32'd1);
        h = 0;
        repeat (6) begin
            @(negedge clk);
            if (d_rvalid[0] || d_rvalid[1]) h++;
        end
        chk("abort no response", 32'(h), 32'd0);

        issue("LW after abort", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h8001_7FFF, 3, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
